branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Registered branch-resolution unit for the RISC core. Sits between control/decode and the PC-update stage.
- Evaluates branch conditions against a latched ALU flag register and computes an absolute, sign-extended target.
- Maintains a parametrised return-address stack (RAS) for call/ret.
- Delivers one resolved redirect per accepted request through a valid/ready output buffer.

Parameters:
- ADDR_W, 32, PC/target width.
- OFF_W, 25, width of the immediate branch offset L; sign-extended to ADDR_W.
- RAS_DEPTH, 4, number of RAS entries (power of 2, >=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- flag_we  in  1  latch ALU flags this cycle
- zflag, carryflag, signflag, overflowflag  in  1 each  ALU flags
- req_valid  in  1  branch request present
- req_ready  out  1  unit can accept a request
- opcode  in  7  branch operation from control
- pc  in  ADDR_W  address of the branch instruction
- L  in  OFF_W  signed offset
- reg_value  in  ADDR_W  rs value for br rs
- flush  in  1  discard the pending output
- out_valid  out  1  resolved result available
- out_ready  in  1  PC stage consumes the result
- taken  out  1  redirect PC
- target  out  ADDR_W  next PC when taken
- ras_overflow  out  1  sticky: push onto full RAS
- ras_underflow  out  1  one-cycle pulse: ret on empty RAS

Behaviour:
Opcodes (binary): 1000000 b, 1000001 br, 1000010 bz, 1000011 bnz, 1000100 bcy, 1000101 bncy, 1000110 bs, 1000111 bns, 1001000 bv, 1001001 bnv, 1001010 call, 1001011 ret. Any other opcode: not taken, target = pc+1.

Flag register:
- Updated at the clock edge when flag_we=1.
- Conditions use the registered flags, never the live inputs.
- If flag_we and req_valid are both high in the same cycle, the request sees the old flags.

Handshake and latency:
- Request accepted when req_valid && req_ready.
- req_ready = !out_valid || out_ready, so back-to-back acceptance at one per cycle is possible.
- Result appears on out_valid exactly 1 cycle after acceptance.
- taken/target hold stable while out_valid && !out_ready.

Target computation (all arithmetic modulo 2^ADDR_W):
- b, call, taken conditionals: pc + sext(L).
- br: reg_value.
- ret: popped RAS top.
- Not-taken conditional: pc+1 with taken=0.

RAS:
- Circular buffer with pointer and count (0..RAS_DEPTH).
- call pushes pc+1 on acceptance.
- Push when full: overwrite the oldest entry, pointer wraps, count stays RAS_DEPTH, ras_overflow sets (cleared only by reset).
- ret pops on acceptance.
- ret with count=0: taken=0, target=pc+1, ras_underflow pulses with out_valid, pointer and count unchanged.

flush:
- Clears out_valid next cycle.
- A request accepted in the same cycle as flush is dropped, but its RAS push/pop still takes effect.

Reset (rst_n=0 at clk edge):
- out_valid=0, taken=0, target=0, flags=0, RAS pointer/count=0, ras_overflow=0, ras_underflow=0.
- RAS contents are don't-care.
- Reset mid-operation discards any pending result.

Decomposition:
- Shared package: opcode localparams (OP_B … OP_RET), flag index constants, and a resolved-result struct {taken, target}.
- One sub-module, ras_stack (push/pop/top/count/overflow), parametrised by ADDR_W and RAS_DEPTH.
- Condition decode and target adder stay in the top module.

Test Plan:
- Reset, then flag_we with z=1; bz pc=100 L=-4 → next cycle out_valid=1, taken=1, target=96. bnz with the same flags → taken=0, target=101.
- flag_we (z=1) and bz in the same cycle, flags previously z=0 → taken=0. A following bz → taken=1.
- call pc=10, then call pc=20, then ret, ret → targets 21, then 11. A third ret → taken=0, target=pc+1, ras_underflow pulse.
- RAS_DEPTH=4: five calls at pc=0,1,2,3,4 → ras_overflow=1. Five rets → 5, 4, 3, 2, then underflow.
- out_ready=0 for 3 cycles with a result pending → req_ready=0, target stable. Release → next request accepted the same cycle.
- br reg_value=0xFFFF_FFF0 → target 0xFFFF_FFF0. Flush while out_valid=1 → out_valid=0 next cycle. Reset asserted mid-stall → all outputs 0.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared opcode map, flag bit positions and resolved-redirect record for the branch resolve unit.
// Combinational content only; no latency and no backpressure.
package branch_resolve_unit_pkg;

    localparam int OPC_W      = 7;
    localparam int BRU_ADDR_W = 32;

    localparam logic [OPC_W-1:0] OP_B    = 7'b1000000;
    localparam logic [OPC_W-1:0] OP_BR   = 7'b1000001;
    localparam logic [OPC_W-1:0] OP_BZ   = 7'b1000010;
    localparam logic [OPC_W-1:0] OP_BNZ  = 7'b1000011;
    localparam logic [OPC_W-1:0] OP_BCY  = 7'b1000100;
    localparam logic [OPC_W-1:0] OP_BNCY = 7'b1000101;
    localparam logic [OPC_W-1:0] OP_BS   = 7'b1000110;
    localparam logic [OPC_W-1:0] OP_BNS  = 7'b1000111;
    localparam logic [OPC_W-1:0] OP_BV   = 7'b1001000;
    localparam logic [OPC_W-1:0] OP_BNV  = 7'b1001001;
    localparam logic [OPC_W-1:0] OP_CALL = 7'b1001010;
    localparam logic [OPC_W-1:0] OP_RET  = 7'b1001011;

    localparam int FLAG_Z    = 0;
    localparam int FLAG_C    = 1;
    localparam int FLAG_S    = 2;
    localparam int FLAG_V    = 3;
    localparam int NUM_FLAGS = 4;

    typedef struct packed {
        logic                  taken;
        logic [BRU_ADDR_W-1:0] target;
    } bru_result_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/flag inputs and redirect outputs between decode, the branch unit and the PC stage.
// Wires only; the slave drives req_ready and the result, the master drives everything else.
interface branch_resolve_unit_if #(
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 25
);
    import branch_resolve_unit_pkg::*;

    logic              flag_we;
    logic              zflag;
    logic              carryflag;
    logic              signflag;
    logic              overflowflag;
    logic              req_valid;
    logic              req_ready;
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] pc;
    logic [OFF_W-1:0]  L;
    logic [ADDR_W-1:0] reg_value;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic              ras_overflow;
    logic              ras_underflow;

    modport master (
        output flag_we, zflag, carryflag, signflag, overflowflag,
        output req_valid, opcode, pc, L, reg_value, flush, out_ready,
        input  req_ready, out_valid, taken, target, ras_overflow, ras_underflow
    );

    modport slave (
        input  flag_we, zflag, carryflag, signflag, overflowflag,
        input  req_valid, opcode, pc, L, reg_value, flush, out_ready,
        output req_ready, out_valid, taken, target, ras_overflow, ras_underflow
    );

endinterface

// File: rtl/branch_resolve_unit_ras_stack.sv
// Circular return-address stack: push/pop commit at the clock edge, top is read combinationally.
// No backpressure: a push when full overwrites the oldest entry and sets a sticky overflow flag.
module ras_stack #(
    parameter  int ADDR_W    = 32,
    parameter  int RAS_DEPTH = 4,
    localparam int PTR_W     = $clog2(RAS_DEPTH),
    localparam int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_dat_i,
    input  logic              pop_i,
    output logic [ADDR_W-1:0] top_dat_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              overflow_o
);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              full, empty;

    assign full  = (count_q == CNT_W'(RAS_DEPTH));
    assign empty = (count_q == '0);

    // ptr_q is the next write slot; when full it also addresses the oldest entry.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push_i) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop_i && !empty) begin
            ptr_d   = ptr_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[ptr_q] <= push_dat_i;
        end
    end

    assign top_dat_o  = mem_q[ptr_q - PTR_W'(1)];
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branch/call/ret against latched flags into a registered redirect, 1 cycle after acceptance.
// One-deep output buffer: req_ready drops only while a result is held by out_ready=0.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int ADDR_W    = BRU_ADDR_W,
    parameter int OFF_W     = 25,
    parameter int RAS_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_resolve_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [NUM_FLAGS-1:0] flags_q;
    logic                 out_valid_q;
    bru_result_t          res_q, res_d;
    logic                 und_q, und_d;

    logic                 req_ready;
    logic                 accept;
    logic                 is_cond, cond_hit;
    logic [ADDR_W-1:0]    off_sext, br_tgt, pc_inc;
    logic [ADDR_W-1:0]    ras_top;
    logic [CNT_W-1:0]     ras_count;
    logic                 ras_empty, ras_ovf;

    assign req_ready = !out_valid_q || bus.out_ready;
    assign accept    = bus.req_valid && req_ready;

    assign off_sext = {{(ADDR_W-OFF_W){bus.L[OFF_W-1]}}, bus.L};
    assign br_tgt   = bus.pc + off_sext;
    assign pc_inc   = bus.pc + ADDR_W'(1);

    assign ras_empty = (ras_count == '0);

    // Conditions look only at flags_q, so a same-cycle flag_we is not yet visible.
    always_comb begin
        is_cond  = 1'b1;
        cond_hit = 1'b0;
        case (bus.opcode)
            OP_BZ:   cond_hit =  flags_q[FLAG_Z];
            OP_BNZ:  cond_hit = !flags_q[FLAG_Z];
            OP_BCY:  cond_hit =  flags_q[FLAG_C];
            OP_BNCY: cond_hit = !flags_q[FLAG_C];
            OP_BS:   cond_hit =  flags_q[FLAG_S];
            OP_BNS:  cond_hit = !flags_q[FLAG_S];
            OP_BV:   cond_hit =  flags_q[FLAG_V];
            OP_BNV:  cond_hit = !flags_q[FLAG_V];
            default: is_cond  = 1'b0;
        endcase
    end

    always_comb begin
        res_d.taken  = 1'b0;
        res_d.target = pc_inc;
        und_d        = 1'b0;
        case (bus.opcode)
            OP_B, OP_CALL: begin
                res_d.taken  = 1'b1;
                res_d.target = br_tgt;
            end
            OP_BR: begin
                res_d.taken  = 1'b1;
                res_d.target = bus.reg_value;
            end
            OP_RET: begin
                if (ras_empty) begin
                    und_d = 1'b1;
                end else begin
                    res_d.taken  = 1'b1;
                    res_d.target = ras_top;
                end
            end
            default: begin
                if (is_cond && cond_hit) begin
                    res_d.taken  = 1'b1;
                    res_d.target = br_tgt;
                end
            end
        endcase
    end

    // The stack commits on acceptance even if flush drops the result.
    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (accept && (bus.opcode == OP_CALL)),
        .push_dat_i (pc_inc),
        .pop_i      (accept && (bus.opcode == OP_RET)),
        .top_dat_o  (ras_top),
        .count_o    (ras_count),
        .overflow_o (ras_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            und_q       <= 1'b0;
        end else begin
            if (bus.flag_we) begin
                flags_q <= {bus.overflowflag, bus.signflag, bus.carryflag, bus.zflag};
            end
            if (bus.flush) begin
                out_valid_q <= 1'b0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                res_q       <= res_d;
                und_q       <= und_d;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready     = req_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.taken         = res_q.taken;
    assign bus.target        = res_q.target;
    assign bus.ras_overflow  = ras_ovf;
    assign bus.ras_underflow = out_valid_q && und_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: expected redirects are queued at issue and checked on out_valid.
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic        und;
    } exp_t;

    logic clk;
    logic rst_n;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    exp_t sb[$];

    branch_resolve_unit_if #(.ADDR_W(32), .OFF_W(25)) bus ();

    branch_resolve_unit #(
        .ADDR_W    (32),
        .OFF_W     (25),
        .RAS_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input string tag);
        exp_t e;
        chk1({tag, "/vld"}, bus.out_valid, 1'b1);
        chkw({tag, "/sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk1({tag, "/taken"}, bus.taken, e.taken);
            chkw({tag, "/target"}, bus.target, e.target);
            chk1({tag, "/und"}, bus.ras_underflow, e.und);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [31:0] pc, input logic [24:0] l,
                         input logic [31:0] rv, input logic tk, input logic [31:0] tg,
                         input logic und);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.opcode    = op;
        bus.pc        = pc;
        bus.L         = l;
        bus.reg_value = rv;
        e.taken       = tk;
        e.target      = tg;
        e.und         = und;
        sb.push_back(e);
    endtask

    task automatic send(input string tag, input logic [6:0] op, input logic [31:0] pc,
                        input logic [24:0] l, input logic [31:0] rv, input logic tk,
                        input logic [31:0] tg, input logic und);
        drive(op, pc, l, rv, tk, tg, und);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.flag_we   = 1'b0;
        collect(tag);
    endtask

    task automatic set_flags(input logic z, input logic c, input logic s, input logic v);
        bus.flag_we      = 1'b1;
        bus.zflag        = z;
        bus.carryflag    = c;
        bus.signflag     = s;
        bus.overflowflag = v;
        @(posedge clk);
        #1;
        bus.flag_we = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.flag_we      = 1'b0;
        bus.zflag        = 1'b0;
        bus.carryflag    = 1'b0;
        bus.signflag     = 1'b0;
        bus.overflowflag = 1'b0;
        bus.req_valid    = 1'b0;
        bus.opcode       = '0;
        bus.pc           = '0;
        bus.L            = '0;
        bus.reg_value    = '0;
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst/vld", bus.out_valid, 1'b0);
        chk1("rst/taken", bus.taken, 1'b0);
        chkw("rst/target", bus.target, 32'd0);
        chk1("rst/ovf", bus.ras_overflow, 1'b0);
        chk1("rst/und", bus.ras_underflow, 1'b0);
        chk1("rst/rdy", bus.req_ready, 1'b1);
        rst_n = 1'b1;

        // Zero flag set, then conditional pair on it.
        set_flags(1'b1, 1'b0, 1'b0, 1'b0);
        send("bz_taken", OP_BZ,  32'd100, 25'h1FFFFFC, 32'd0, 1'b1, 32'd96,  1'b0);
        send("bnz_nt",   OP_BNZ, 32'd100, 25'h1FFFFFC, 32'd0, 1'b0, 32'd101, 1'b0);

        // Remaining flag conditions with C=1, V=1.
        set_flags(1'b0, 1'b1, 1'b0, 1'b1);
        send("bcy",  OP_BCY,  32'd200, 25'd8,        32'd0, 1'b1, 32'd208, 1'b0);
        send("bncy", OP_BNCY, 32'd200, 25'd8,        32'd0, 1'b0, 32'd201, 1'b0);
        send("bs",   OP_BS,   32'd200, 25'd8,        32'd0, 1'b0, 32'd201, 1'b0);
        send("bns",  OP_BNS,  32'd200, 25'h1FFFF38,  32'd0, 1'b1, 32'd0,   1'b0);
        send("bv",   OP_BV,   32'd200, 25'd8,        32'd0, 1'b1, 32'd208, 1'b0);
        send("bnv",  OP_BNV,  32'd200, 25'd8,        32'd0, 1'b0, 32'd201, 1'b0);
        send("bz_z0", OP_BZ,  32'd200, 25'd8,        32'd0, 1'b0, 32'd201, 1'b0);
        send("b_neg", OP_B,   32'd5,   25'h1FFFFFF,  32'd0, 1'b1, 32'd4,   1'b0);

        // Flag write in the same cycle as the request: request sees old Z=0.
        bus.flag_we      = 1'b1;
        bus.zflag        = 1'b1;
        bus.carryflag    = 1'b0;
        bus.overflowflag = 1'b0;
        send("bz_oldflag", OP_BZ, 32'd50, 25'd3, 32'd0, 1'b0, 32'd51, 1'b0);
        send("bz_newflag", OP_BZ, 32'd50, 25'd3, 32'd0, 1'b1, 32'd53, 1'b0);

        // Call/ret nesting and underflow.
        send("call10", OP_CALL, 32'd10, 25'd100, 32'd0, 1'b1, 32'd110, 1'b0);
        send("call20", OP_CALL, 32'd20, 25'd5,   32'd0, 1'b1, 32'd25,  1'b0);
        send("ret1",   OP_RET,  32'd30, 25'd0,   32'd0, 1'b1, 32'd21,  1'b0);
        send("ret2",   OP_RET,  32'd31, 25'd0,   32'd0, 1'b1, 32'd11,  1'b0);
        send("ret_und", OP_RET, 32'd40, 25'd0,   32'd0, 1'b0, 32'd41,  1'b1);
        idle();
        chk1("und_pulse_end", bus.ras_underflow, 1'b0);

        // Fill past depth: oldest entry is overwritten.
        for (int i = 0; i < 5; i++) begin
            send("call_fill", OP_CALL, 32'(i), 25'd1, 32'd0, 1'b1, 32'(i + 1), 1'b0);
            if (i == 3) chk1("ovf_at_full", bus.ras_overflow, 1'b0);
        end
        chk1("ovf_set", bus.ras_overflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send("ret_drain", OP_RET, 32'd100, 25'd0, 32'd0, 1'b1, 32'(5 - i), 1'b0);
        end
        send("ret_drain_und", OP_RET, 32'd100, 25'd0, 32'd0, 1'b0, 32'd101, 1'b1);
        chk1("ovf_sticky", bus.ras_overflow, 1'b1);

        // Output stall with a second request waiting.
        idle();
        bus.out_ready = 1'b0;
        send("stall_b", OP_B, 32'd300, 25'd10, 32'd0, 1'b1, 32'd310, 1'b0);
        drive(OP_B, 32'd400, 25'd1, 32'd0, 1'b1, 32'd401, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk1("stall/rdy", bus.req_ready, 1'b0);
            chk1("stall/vld", bus.out_valid, 1'b1);
            chkw("stall/target", bus.target, 32'd310);
        end
        bus.out_ready = 1'b1;
        #1;
        chk1("release/rdy", bus.req_ready, 1'b1);
        idle();
        bus.req_valid = 1'b0;
        collect("after_release");

        send("br", OP_BR, 32'd0, 25'd0, 32'hFFFF_FFF0, 1'b1, 32'hFFFF_FFF0, 1'b0);

        // Flush a held result.
        idle();
        bus.out_ready = 1'b0;
        send("pre_flush", OP_B, 32'd500, 25'd2, 32'd0, 1'b1, 32'd502, 1'b0);
        bus.flush = 1'b1;
        idle();
        bus.flush = 1'b0;
        chk1("flush/vld", bus.out_valid, 1'b0);
        bus.out_ready = 1'b1;

        // Flushed call still pushes its return address.
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.opcode    = OP_CALL;
        bus.pc        = 32'd60;
        bus.L         = 25'd0;
        idle();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        chk1("flush_call/vld", bus.out_valid, 1'b0);
        send("ret_after_flush", OP_RET, 32'd70, 25'd0, 32'd0, 1'b1, 32'd61, 1'b0);

        // Reset during a stall discards the pending result.
        idle();
        bus.out_ready = 1'b0;
        send("pre_reset", OP_B, 32'd600, 25'd1, 32'd0, 1'b1, 32'd601, 1'b0);
        rst_n = 1'b0;
        idle();
        chk1("mid_rst/vld", bus.out_valid, 1'b0);
        chk1("mid_rst/taken", bus.taken, 1'b0);
        chkw("mid_rst/target", bus.target, 32'd0);
        chk1("mid_rst/ovf", bus.ras_overflow, 1'b0);
        chk1("mid_rst/und", bus.ras_underflow, 1'b0);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;

        send("unknown_op", 7'h00, 32'd7, 25'd9, 32'd0, 1'b0, 32'd8, 1'b0);
        idle();
        chkw("sb_final", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
